// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the 4-digit BCD stopwatch control and datapath.
// Holds the controller state encoding, the error codes and the two load presets.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        IDLE  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        LIMIT = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_REV   = 2'b01;
    localparam logic [1:0] ERR_SPEED = 2'b10;

    // Presets selected by load_sel: 0 = counting up, 1 = counting down
    localparam logic [15:0] PRESET_UP = 16'h1020;
    localparam logic [15:0] PRESET_DN = 16'h4930;

endpackage

// File: rtl/btn_sync_edge.sv
// Synchroniser for one asynchronous board input plus a rising-edge pulse.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset, clears the chain
//   raw   - asynchronous input level
//   level - synchronised level (last chain stage)
//   rise  - one-cycle registered pulse, high in the same cycle level first reads 1
module btn_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Edge is taken from the last two stages so the pulse lines up with level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            rise   <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/stopwatch_ctrl.sv
// Control FSM for the 4-digit BCD stopwatch: sequences preset loading,
// run/pause/limit/error handling, count direction, speed select and the
// flashing error display.
// Ports:
//   clk_in, RESET      - clock, synchronous active-high reset
//   tick               - one-cycle base-rate pulse
//   start_btn .. speed_dn_btn, reverse_sw - raw asynchronous board inputs
//   limit_hit          - counter has reached the bound for the current direction
//   count_en           - combinational counter advance enable
//   dir, load, load_sel, step_add, step_sub, speed_sel, err_code, flash - registered controls
//   state_o            - current state for debug
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SPEED_W     = 2,
    parameter int unsigned ERR_HOLD    = 8
) (
    input  logic               clk_in,
    input  logic               RESET,
    input  logic               tick,
    input  logic               start_btn,
    input  logic               clear_btn,
    input  logic               step_btn,
    input  logic               reverse_sw,
    input  logic               speed_up_btn,
    input  logic               speed_dn_btn,
    input  logic               limit_hit,
    output logic               count_en,
    output logic               dir,
    output logic               load,
    output logic               load_sel,
    output logic               step_add,
    output logic               step_sub,
    output logic [SPEED_W-1:0] speed_sel,
    output logic [1:0]         err_code,
    output logic               flash,
    output logic [2:0]         state_o
);

    localparam int unsigned CNT_W = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
    localparam logic [SPEED_W-1:0] SPEED_MAX = '1;

    logic start_rise, clr_rise, step_rise, up_rise, dn_rise, rev_lvl;
    logic start_lvl_unused, clr_lvl_unused, step_lvl_unused;
    logic up_lvl_unused, dn_lvl_unused, rev_rise_unused;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (.clk(clk_in), .rst(RESET), .raw(start_btn),    .level(start_lvl_unused), .rise(start_rise));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clear (.clk(clk_in), .rst(RESET), .raw(clear_btn),    .level(clr_lvl_unused),   .rise(clr_rise));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step  (.clk(clk_in), .rst(RESET), .raw(step_btn),     .level(step_lvl_unused),  .rise(step_rise));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rev   (.clk(clk_in), .rst(RESET), .raw(reverse_sw),   .level(rev_lvl),          .rise(rev_rise_unused));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_up    (.clk(clk_in), .rst(RESET), .raw(speed_up_btn), .level(up_lvl_unused),    .rise(up_rise));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dn    (.clk(clk_in), .rst(RESET), .raw(speed_dn_btn), .level(dn_lvl_unused),    .rise(dn_rise));

    state_t             state_q, state_nxt, saved_q, saved_nxt;
    logic [CNT_W-1:0]   err_cnt, cnt_nxt;
    logic               dir_nxt, load_nxt, load_sel_nxt, step_add_nxt, step_sub_nxt, flash_nxt;
    logic [SPEED_W-1:0] speed_nxt;
    logic [1:0]         err_nxt;
    logic               acted;

    // State and registered control outputs
    always_ff @(posedge clk_in) begin
        if (RESET) begin
            state_q   <= LOAD;
            saved_q   <= IDLE;
            err_cnt   <= '0;
            dir       <= 1'b0;
            load      <= 1'b0;
            load_sel  <= 1'b0;
            step_add  <= 1'b0;
            step_sub  <= 1'b0;
            speed_sel <= '0;
            err_code  <= ERR_NONE;
            flash     <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            saved_q   <= saved_nxt;
            err_cnt   <= cnt_nxt;
            dir       <= dir_nxt;
            load      <= load_nxt;
            load_sel  <= load_sel_nxt;
            step_add  <= step_add_nxt;
            step_sub  <= step_sub_nxt;
            speed_sel <= speed_nxt;
            err_code  <= err_nxt;
            flash     <= flash_nxt;
        end
    end

    // Next state; 'acted' marks that a higher-priority event consumed this cycle
    always_comb begin
        state_nxt    = state_q;
        saved_nxt    = saved_q;
        cnt_nxt      = '0;
        dir_nxt      = dir;
        load_nxt     = 1'b0;
        step_add_nxt = 1'b0;
        step_sub_nxt = 1'b0;
        speed_nxt    = speed_sel;
        err_nxt      = err_code;
        flash_nxt    = flash;
        acted        = 1'b0;

        if (clr_rise) begin
            state_nxt = LOAD;
            err_nxt   = ERR_NONE;
            flash_nxt = 1'b1;
        end else begin
            unique case (state_q)
                LOAD: begin
                    load_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
                IDLE: begin
                    // A direction change reloads so the preset matches the new direction
                    if (rev_lvl != dir) begin
                        dir_nxt   = rev_lvl;
                        state_nxt = LOAD;
                        acted     = 1'b1;
                    end else if (start_rise) begin
                        state_nxt = RUN;
                        acted     = 1'b1;
                    end
                end
                RUN: begin
                    if (limit_hit) begin
                        state_nxt = LIMIT;
                        acted     = 1'b1;
                    end else if (rev_lvl != dir) begin
                        state_nxt = ERROR;
                        saved_nxt = PAUSE;
                        err_nxt   = ERR_REV;
                        acted     = 1'b1;
                    end else if (start_rise) begin
                        state_nxt = PAUSE;
                        acted     = 1'b1;
                    end
                end
                PAUSE: begin
                    dir_nxt = rev_lvl;
                    if (start_rise) begin
                        state_nxt = RUN;
                        acted     = 1'b1;
                    end
                end
                LIMIT: begin
                    if (rev_lvl != dir) begin
                        dir_nxt   = rev_lvl;
                        state_nxt = PAUSE;
                        acted     = 1'b1;
                    end
                end
                ERROR: begin
                    acted   = 1'b1;
                    cnt_nxt = err_cnt;
                    if (tick) begin
                        if (err_cnt == CNT_W'(ERR_HOLD - 1)) begin
                            state_nxt = saved_q;
                            err_nxt   = ERR_NONE;
                            flash_nxt = 1'b1;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt   = err_cnt + 1'b1;
                            flash_nxt = ~flash;
                        end
                    end
                end
                default: state_nxt = LOAD;
            endcase

            // Speed edges; a simultaneous up/down pair is dropped
            if (!acted && (up_rise | dn_rise)) begin
                acted = 1'b1;
                if (up_rise != dn_rise) begin
                    if ((up_rise && speed_sel == SPEED_MAX) || (dn_rise && speed_sel == '0)) begin
                        saved_nxt = (state_nxt == RUN) ? PAUSE : state_nxt;
                        state_nxt = ERROR;
                        err_nxt   = ERR_SPEED;
                    end else if (up_rise) begin
                        speed_nxt = speed_sel + 1'b1;
                    end else begin
                        speed_nxt = speed_sel - 1'b1;
                    end
                end
            end

            if (!acted && state_q == PAUSE && step_rise) begin
                step_add_nxt = ~dir;
                step_sub_nxt = dir;
            end
        end

        load_sel_nxt = dir_nxt;
    end

    assign count_en = (state_q == RUN) & tick & ~limit_hit;
    assign state_o  = 3'(state_q);

endmodule
